// File: rtl/struct_helpers.sv
// rtl/struct_helpers.sv - shared fetch/decode types and default sizes
//
// Purpose: shared package; carries the instruction-buffer entry type and the
//          default lane/depth configuration.
// Contents: ibuf_entry_t {pc, instr}, IBUF_WIDTH_DEF, IBUF_DEPTH_DEF.
package struct_helpers;

  localparam int IBUF_WIDTH_DEF = 2;
  localparam int IBUF_DEPTH_DEF = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ibuf_entry_t;

endpackage

// File: rtl/inst_buffer_n_ram.sv
// rtl/inst_buffer_n_ram.sv - multi-port storage array for the instruction buffer
//
// Purpose: DEPTH x ibuf_entry_t array, WIDTH synchronous write ports and
//          WIDTH combinational read ports. Addresses wrap modulo DEPTH.
// Ports:
//   clk    in   write clock
//   we     in   per-port write enable
//   waddr  in   per-port write address
//   wdata  in   per-port write data
//   raddr  in   per-port read address
//   rdata  out  per-port read data (combinational)
module ibuf_ram
  import struct_helpers::*;
#(
  parameter int WIDTH = IBUF_WIDTH_DEF,
  parameter int DEPTH = IBUF_DEPTH_DEF,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic        [WIDTH-1:0]         we,
  input  logic        [WIDTH-1:0][AW-1:0] waddr,
  input  ibuf_entry_t [WIDTH-1:0]         wdata,
  input  logic        [WIDTH-1:0][AW-1:0] raddr,
  output ibuf_entry_t [WIDTH-1:0]         rdata
);

  ibuf_entry_t mem [DEPTH];

  // Enabled ports always target distinct slots, so write order is irrelevant.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (we[i]) mem[waddr[i]] <= wdata[i];
    end
  end

  always_comb begin
    for (int i = 0; i < WIDTH; i++) rdata[i] = mem[raddr[i]];
  end

endmodule

// File: rtl/inst_buffer_n.sv
// rtl/inst_buffer_n.sv - N-lane in-order instruction buffer between fetch and decode
//
// Purpose: WIDTH-lane circular queue of DEPTH entries. Accepts up to WIDTH
//          compacted {pc, instr} packets per cycle and presents the oldest
//          WIDTH packets (lane 0 oldest) with partial consumption and flush.
// Optional: IBUF_BYPASS_EN - when empty and not flushing, incoming packets
//          appear on out_* in the same cycle; consumed lanes are not stored.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid     per-lane fetch valid        in_pkt    per-lane packet
//   in_ready     room for a full WIDTH group flush     discard all contents
//   out_valid    per-lane output valid       out_pkt   oldest packets
//   out_take     lanes consumed this cycle   count     occupancy
//   empty        count == 0
module inst_buffer_n
  import struct_helpers::*;
#(
  parameter int WIDTH = IBUF_WIDTH_DEF,
  parameter int DEPTH = IBUF_DEPTH_DEF,
  parameter int XLEN  = 32,
  localparam int CW = $clog2(WIDTH + 1),
  localparam int NW = $clog2(DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic        [WIDTH-1:0]       in_valid,
  input  ibuf_entry_t [WIDTH-1:0]       in_pkt,
  output logic                          in_ready,
  input  logic                          flush,
  output logic        [WIDTH-1:0]       out_valid,
  output ibuf_entry_t [WIDTH-1:0]       out_pkt,
  input  logic        [CW-1:0]          out_take,
  output logic        [NW-1:0]          count,
  output logic                          empty
);

  localparam int AW = $clog2(DEPTH);

  if (XLEN != 32) begin : g_bad_xlen
    $error("inst_buffer_n: entry type is fixed at 32-bit pc/instr");
  end
  if ((DEPTH & (DEPTH - 1)) != 0 || DEPTH < 2 * WIDTH) begin : g_bad_depth
    $error("inst_buffer_n: DEPTH must be a power of two and >= 2*WIDTH");
  end

  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [NW-1:0] cnt;

  logic        [WIDTH-1:0][CW-1:0] pos;
  ibuf_entry_t [WIDTH-1:0]         cpkt;
  logic        [CW-1:0]            n_in, n_acc, skip, n_wr;
  logic        [NW-1:0]            n_out;
  logic                            accept;

  logic        [WIDTH-1:0]         we;
  logic        [WIDTH-1:0][AW-1:0] waddr, raddr;
  ibuf_entry_t [WIDTH-1:0]         rdata;

  assign count    = cnt;
  assign empty    = (cnt == '0);
  assign in_ready = (NW'(DEPTH) - cnt) >= NW'(WIDTH);
  assign accept   = in_ready & ~flush;

  // pos[i] is the number of valid lanes below i, i.e. the compacted slot
  // that lane i lands in.
  always_comb begin
    n_in = '0;
    pos  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pos[i] = n_in;
      if (in_valid[i]) n_in = n_in + CW'(1);
    end
    cpkt = '0;
    for (int j = 0; j < WIDTH; j++) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (in_valid[i] && pos[i] == CW'(j)) cpkt[j] = in_pkt[i];
      end
    end
  end

  assign n_acc = accept ? n_in : '0;

  // Over-asking decode is clamped to what is actually present.
  always_comb begin
    n_out = NW'(out_take);
    if (n_out > cnt) n_out = cnt;
    if (n_out > NW'(WIDTH)) n_out = NW'(WIDTH);
    if (flush) n_out = '0;
  end

`ifdef IBUF_BYPASS_EN
  // Empty buffer: decode may consume fresh packets directly; those lanes
  // are skipped on the write side.
  always_comb begin
    skip = '0;
    if (cnt == '0 && !flush) skip = (out_take < n_in) ? out_take : n_in;
  end
`else
  assign skip = '0;
`endif

  assign n_wr = n_acc - skip;

  always_comb begin
    for (int j = 0; j < WIDTH; j++) begin
      we[j]    = accept && (CW'(j) < n_in) && (CW'(j) >= skip);
      waddr[j] = wr_ptr + AW'(j) - AW'(skip);
      raddr[j] = rd_ptr + AW'(j);
    end
  end

  ibuf_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (cpkt),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      out_valid[i] = cnt > NW'(i);
      out_pkt[i]   = out_valid[i] ? rdata[i] : '0;
`ifdef IBUF_BYPASS_EN
      if (cnt == '0 && !flush) begin
        out_valid[i] = CW'(i) < n_in;
        out_pkt[i]   = cpkt[i];
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      rd_ptr <= rd_ptr + AW'(n_out);
      wr_ptr <= wr_ptr + AW'(n_wr);
      cnt    <= cnt + NW'(n_wr) - n_out;
    end
  end

endmodule
